// File: rtl/serial_decrement_if.sv
// rtl/serial_decrement_if.sv - operand/result handshake bundle for the bit-serial decrementer
interface serial_decrement_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_borrow;

    // Operand source / result sink side
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_zero,
        input  out_borrow
    );

    // Decrementer side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_zero,
        output out_borrow
    );
endinterface

// File: rtl/serial_decrement.sv
// rtl/serial_decrement.sv - bit-serial LSB-first decrementer with a single borrow flip-flop
module serial_decrement #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    serial_decrement_if.slave  dec_if
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             r_bit;
    logic             done;

    // Next-state: load operand in IDLE, rotate one result bit in per SHIFT cycle, hold in DONE
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        r_bit    = sr_q[0] ^ borrow_q;
        case (state_q)
            S_IDLE: begin
                if (dec_if.in_valid) begin
                    sr_d     = dec_if.in_data;
                    borrow_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Result bit enters at the MSB so after WIDTH shifts the word is back in place
                sr_d     = {r_bit, sr_q[WIDTH-1:1]};
                borrow_d = ~sr_q[0] & borrow_q;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (dec_if.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decode registered state only; result fields read zero outside DONE
    assign done              = (state_q == S_DONE);
    assign dec_if.in_ready   = (state_q == S_IDLE);
    assign dec_if.out_valid  = done;
    assign dec_if.out_data   = done ? sr_q : '0;
    assign dec_if.out_zero   = done && (sr_q == '0);
    assign dec_if.out_borrow = done && borrow_q;
endmodule
